// File: rtl/spaceship_led_scanner.sv
// spaceship_led_scanner
// Multi-channel LED position scanner. Every channel steps its position by STEP
// on a shared prescaled tick while its enable is high. At the top of the range
// it either wraps back to MIN_POS or, in bounce mode, reverses direction.
// Bounce mode is built only when SPACESHIP_LED_BOUNCE_EN is defined. Without
// it the scanner always wraps, ignores mode and holds dir at 0.
// Handshake: none. Inputs are sampled on every rising Clk edge. out_state, dir
// and edge_pulse are registered and change one cycle after the tick edge that
// caused them.
module spaceship_led_scanner #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int STEP     = 2,
    parameter int MIN_POS  = 2,
    parameter int MAX_POS  = 14,
    parameter int PRESCALE = 1
) (
    input  logic                      Clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] default_state,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      mode,
    output logic [CHANNELS*WIDTH-1:0] out_state,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       edge_pulse
);

    // Per-channel direction state, exposed directly on the dir output.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int              CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] MAX_P   = WIDTH'(MAX_POS);
    // Sums are one bit wider than a position so pos+STEP can never wrap.
    localparam logic [WIDTH:0]  STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]  MAX_X    = (WIDTH + 1)'(MAX_POS);
`ifdef SPACESHIP_LED_BOUNCE_EN
    localparam logic [WIDTH-1:0] STEP_P     = WIDTH'(STEP);
    localparam logic [WIDTH:0]   LOW_TURN_X = (WIDTH + 1)'(MIN_POS + STEP);
`else
    // mode has no effect in the wrap-only build.
    logic unused_mode;
    assign unused_mode = mode;
`endif

    logic [CW-1:0]       cnt_q;
    logic                tick;
    logic [WIDTH-1:0]    pos_q     [CHANNELS];
    logic [WIDTH-1:0]    pos_d     [CHANNELS];
    logic [WIDTH-1:0]    reset_pos [CHANNELS];
    logic [WIDTH:0]      up_sum    [CHANNELS];
    dir_t                dir_q     [CHANNELS];
    dir_t                dir_d     [CHANNELS];
    logic [CHANNELS-1:0] edge_d;
    logic [CHANNELS-1:0] edge_q;

    assign tick = (cnt_q == CNT_LAST);

    // Shared prescaler: free-running 0..PRESCALE-1, independent of en.
    always_ff @(posedge Clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Reset positions: out-of-range default_state values fall back to MIN_POS.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            reset_pos[i] = default_state[i*WIDTH +: WIDTH];
            if ((reset_pos[i] < MIN_P) || (reset_pos[i] > MAX_P)) begin
                reset_pos[i] = MIN_P;
            end
        end
    end

    // Next position, direction and edge flag for each channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pos_d[i]  = pos_q[i];
            dir_d[i]  = dir_q[i];
            edge_d[i] = 1'b0;
            up_sum[i] = {1'b0, pos_q[i]} + STEP_X;
            if (tick && en[i]) begin
`ifdef SPACESHIP_LED_BOUNCE_EN
                if (mode) begin
                    if (dir_q[i] == DIR_UP) begin
                        if (up_sum[i] > MAX_X) begin
                            pos_d[i]  = pos_q[i] - STEP_P;
                            dir_d[i]  = DIR_DOWN;
                            edge_d[i] = 1'b1;
                        end else begin
                            pos_d[i] = up_sum[i][WIDTH-1:0];
                        end
                    end else begin
                        if ({1'b0, pos_q[i]} < LOW_TURN_X) begin
                            pos_d[i]  = up_sum[i][WIDTH-1:0];
                            dir_d[i]  = DIR_UP;
                            edge_d[i] = 1'b1;
                        end else begin
                            pos_d[i] = pos_q[i] - STEP_P;
                        end
                    end
                end else
`endif
                begin
                    // Wrap: always moving up, so a pending down direction is cleared.
                    dir_d[i] = DIR_UP;
                    if (up_sum[i] > MAX_X) begin
                        pos_d[i]  = MIN_P;
                        edge_d[i] = 1'b1;
                    end else begin
                        pos_d[i] = up_sum[i][WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Channel state registers; rst overrides tick, en and mode.
    always_ff @(posedge Clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pos_q[i] <= reset_pos[i];
                dir_q[i] <= DIR_UP;
            end
            edge_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pos_q[i] <= pos_d[i];
                dir_q[i] <= dir_d[i];
            end
            edge_q <= edge_d;
        end
    end

    // Pack the per-channel registers onto the output buses.
    always_comb begin
        out_state = '0;
        dir       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_state[i*WIDTH +: WIDTH] = pos_q[i];
            dir[i]                      = dir_q[i];
        end
        edge_pulse = edge_q;
    end

endmodule

// File: tb/tb_spaceship_led_scanner.sv
// tb_spaceship_led_scanner
// Bench for spaceship_led_scanner. Instance dut_a uses the default parameters
// and is driven from a table of vectors. Instance dut_b uses PRESCALE=3 and is
// driven by hand-written multi-cycle sequences. The bounce-mode sequences are
// built only when SPACESHIP_LED_BOUNCE_EN is defined.
module tb_spaceship_led_scanner;

  logic       Clk = 1'b0;
  logic       rst;
  logic [7:0] default_state;
  logic [1:0] en;
  logic [1:0] en_b;
  logic       mode;
  logic [7:0] out_a;
  logic [1:0] dir_a;
  logic [1:0] edge_a;
  logic [7:0] out_b;
  logic [1:0] dir_b;
  logic [1:0] edge_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [7:0] def;
    logic [1:0] en;
    logic [7:0] exp_out;
    logic [1:0] exp_dir;
    logic [1:0] exp_edge;
  } vec_t;

  vec_t vecs[16];

  // clock / reset block
  always #5 Clk = ~Clk;

  spaceship_led_scanner dut_a (
    .Clk(Clk), .rst(rst), .default_state(default_state), .en(en), .mode(mode),
    .out_state(out_a), .dir(dir_a), .edge_pulse(edge_a)
  );

  spaceship_led_scanner #(.PRESCALE(3)) dut_b (
    .Clk(Clk), .rst(rst), .default_state(default_state), .en(en_b), .mode(mode),
    .out_state(out_b), .dir(dir_b), .edge_pulse(edge_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one clock and sample 1 ns after the rising edge
  task automatic step_clk();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] def);
    rst = 1'b1;
    default_state = def;
    step_clk();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    default_state = 8'h52;
    en = 2'b11;
    en_b = 2'b01;
    mode = 1'b0;

    // ch1 in the high nibble, ch0 in the low nibble
    vecs[0]  = '{1'b1, 8'h52, 2'b11, 8'h52, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 8'h52, 2'b11, 8'h74, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 8'h52, 2'b11, 8'h96, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 8'h52, 2'b11, 8'hB8, 2'b00, 2'b00};
    vecs[4]  = '{1'b0, 8'h52, 2'b11, 8'hDA, 2'b00, 2'b00};
    vecs[5]  = '{1'b0, 8'h52, 2'b11, 8'h2C, 2'b00, 2'b10};
    vecs[6]  = '{1'b0, 8'h52, 2'b11, 8'h4E, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 8'h52, 2'b11, 8'h62, 2'b00, 2'b01};
    vecs[8]  = '{1'b0, 8'h52, 2'b11, 8'h84, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 8'h52, 2'b01, 8'h86, 2'b00, 2'b00};
    vecs[10] = '{1'b0, 8'h52, 2'b00, 8'h86, 2'b00, 2'b00};
    vecs[11] = '{1'b0, 8'h52, 2'b10, 8'hA6, 2'b00, 2'b00};
    vecs[12] = '{1'b1, 8'hF0, 2'b11, 8'h22, 2'b00, 2'b00};
    vecs[13] = '{1'b1, 8'h0F, 2'b11, 8'h22, 2'b00, 2'b00};
    vecs[14] = '{1'b1, 8'h3E, 2'b11, 8'h3E, 2'b00, 2'b00};
    vecs[15] = '{1'b0, 8'h3E, 2'b11, 8'h52, 2'b00, 2'b01};

    // table-driven wrap, enable and reset-clamp vectors on dut_a
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      default_state = vecs[i].def;
      en = vecs[i].en;
      step_clk();
      check($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_dir", i), 32'(dir_a), 32'(vecs[i].exp_dir));
      check($sformatf("vec%0d_edge", i), 32'(edge_a), 32'(vecs[i].exp_edge));
    end

    // PRESCALE=3: ch0 advances every third edge, ch1 (en_b[1]=0) holds at 5
    en_b = 2'b01;
    do_reset(8'h52);
    check("pre_reset_out", 32'(out_b), 32'h52);
    for (int k = 1; k <= 9; k++) exp_q.push_back(8'(8'h50 | (2 + 2 * (k / 3))));
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] e;
      step_clk();
      e = exp_q.pop_front();
      check($sformatf("pre_k%0d_out", k), 32'(out_b), 32'(e));
      check($sformatf("pre_k%0d_edge", k), 32'(edge_b), 32'h0);
    end

    // mid-sweep reset restarts the prescaler
    do_reset(8'h52);
    repeat (4) step_clk();
    check("mid_before_rst", 32'(out_b), 32'h54);
    do_reset(8'h52);
    check("mid_rst_out", 32'(out_b), 32'h52);
    step_clk();
    check("mid_e1", 32'(out_b), 32'h52);
    step_clk();
    check("mid_e2", 32'(out_b), 32'h52);
    step_clk();
    check("mid_e3", 32'(out_b), 32'h54);

`ifdef SPACESHIP_LED_BOUNCE_EN
    begin
      logic [3:0] bpos[8] = '{4'd14, 4'd12, 4'd10, 4'd8, 4'd6, 4'd4, 4'd2, 4'd4};
      logic       bdir[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       bedg[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [3:0] wpos[4] = '{4'd10, 4'd12, 4'd14, 4'd2};
      logic       wedg[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

      // full bounce sweep from 12
      mode = 1'b1;
      en = 2'b01;
      do_reset(8'h2C);
      for (int k = 0; k < 8; k++) begin
        step_clk();
        check($sformatf("bnc%0d_pos", k), 32'(out_a[3:0]), 32'(bpos[k]));
        check($sformatf("bnc%0d_dir", k), 32'(dir_a[0]), 32'(bdir[k]));
        check($sformatf("bnc%0d_edge", k), 32'(edge_a[0]), 32'(bedg[k]));
      end

      // bounce -> wrap while moving down at 8
      do_reset(8'h2C);
      repeat (4) step_clk();
      check("sw_pos8", 32'(out_a[3:0]), 32'd8);
      check("sw_dir1", 32'(dir_a[0]), 32'd1);
      mode = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step_clk();
        check($sformatf("sw%0d_pos", k), 32'(out_a[3:0]), 32'(wpos[k]));
        check($sformatf("sw%0d_dir", k), 32'(dir_a[0]), 32'd0);
        check($sformatf("sw%0d_edge", k), 32'(edge_a[0]), 32'(wedg[k]));
      end

      // reset while at 10 moving down
      mode = 1'b1;
      do_reset(8'h2C);
      repeat (3) step_clk();
      check("rd_pos10", 32'(out_a[3:0]), 32'd10);
      do_reset(8'h2C);
      check("rd_out", 32'(out_a[3:0]), 32'd12);
      check("rd_dir", 32'(dir_a[0]), 32'd0);
      check("rd_edge", 32'(edge_a[0]), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
